pipelined_ctrl_unit: RTL and testbench
======================================

Name: pipelined_ctrl_unit

Overview:
Registered decode/control stage between IF/ID and ID/EX of the 5-stage ARM pipeline. It decodes the instruction opcode into a packed control word and registers it, with the destination register, into the EX stage. Unlike the single-cycle combinational decoder, it adds load-use hazard bubbling, a multi-cycle MUL issue FSM, flush and downstream stall handling, and illegal-opcode flagging. It is parametrised in opcode width, register-address width and MUL latency.

Parameters:
OPC_W, 11, opcode width; decode uses opcode[OPC_W-1 -: 11], must be >= 11
REG_AW, 5, register address width; register index all-ones is the zero register (X31)
MUL_CYCLES, 4, total EX occupancy of MUL; legal range 1..15

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_valid  in  1  instruction present in ID
opcode  in  OPC_W  instruction opcode field
id_rn  in  REG_AW  first source register
id_rm  in  REG_AW  second source (Rm, or Rt for STUR/CBZ)
id_rd  in  REG_AW  destination register (forced to all-ones for BL)
ex_hold  in  1  downstream stall; EX registers hold
flush  in  1  branch-taken squash of ID and EX
id_stall  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  EX-stage control word valid
ex_ctrl  out  18  control word: [0]uncondBr [1]branch [2]Reg2Loc [3]ALU_Src [4]RegWrite [5]ALU_SH [6]Imm [7]memToReg [8]memWrite [9]shiftDirn [10]ALU_on [11]set_flags [12]branchReg [13]branchLink [14]memRead [16:15]fwdEn [17]mul
ex_rd  out  REG_AW  EX-stage destination register
illegal  out  1  one-cycle pulse: valid ID opcode matched nothing

Behaviour:
- Decode, first match wins: B bOp=000101; B.cond cbOp=01010100; BL bOp=100101; BR 11010110000; CBZ cbOp=10110100; ADDI iOp=1001000100; ADDS 10101011000; LDUR 11111000010; STUR 11111000000; SUBS 11101011000; MUL 10011011000 (new).
- Control values per class are the established ISA control table with every don't-care driven 0. MUL: Reg2Loc=1, RegWrite=1, ALU_on=1, fwdEn=11, mul=1, all other bits 0.
- Unmatched opcode with id_valid=1: decoded word is all-zero, the slot issues as a bubble (ex_valid=0), and illegal pulses for one cycle.
- uses_rm = Reg2Loc | memWrite | (CBZ class) | mul.
- Load-use hazard (combinational): ex_valid & ex_ctrl[14] & ex_rd != all-ones & id_valid & (ex_rd==id_rn | (uses_rm & ex_rd==id_rm)). When set: id_stall=1, a bubble is issued, and the ID instruction re-presents next cycle.
- FSM states are RUN and MUL_BUSY, with a 4-bit counter cnt.
  - RUN: on accepting a MUL with MUL_CYCLES>1, go to MUL_BUSY with cnt=MUL_CYCLES-1 and id_stall=1 in the same cycle.
  - MUL_BUSY: id_stall=1. Each non-held cycle, issue a bubble and decrement cnt. When cnt reaches 1 and is not held, return to RUN; id_stall=0 that cycle so the next instruction is accepted. Net result: MUL then exactly MUL_CYCLES-1 bubbles.
- Issue and accept rules:
  - An instruction is "accepted" when id_valid & !hazard & state==RUN & !ex_hold & !flush.
  - Accept: ex_ctrl/ex_rd load the decode, ex_valid=1.
  - Not accepted and not held: ex_valid<=0 (bubble); ex_ctrl is zeroed.
- Priority, highest first: rst > flush > ex_hold > hazard/MUL_BUSY > accept.
- flush: ex_valid<=0, ex_ctrl<=0, state<=RUN, cnt<=0, illegal=0. This applies even mid-MUL_BUSY or while ex_hold=1.
- ex_hold (no flush): ex_valid, ex_ctrl, ex_rd, state and cnt all hold. id_stall=1.
- Reset values: ex_valid=0, ex_ctrl=0, ex_rd=0, state=RUN, cnt=0, illegal=0, id_stall=0. Reset mid-MUL aborts the sequence with no further bubbles counted.
- id_valid=0: bubble issued, no stall, no illegal.
- Latency: one clock from ID accept to ex_ctrl.

Test Plan:
- Reset then ADDS opcode 10101011000, id_rd=3 -> next cycle ex_valid=1, ex_ctrl bits 2,4,10,11 set, fwdEn=11, ex_rd=3; no stall.
- LDUR id_rd=5, then ADDS with id_rm=5 -> id_stall=1 for one cycle with a bubble (ex_valid=0), then the ADDS issues. Repeat with LDUR rd=31 -> no stall.
- MUL with MUL_CYCLES=4 followed by ADDI -> MUL issues at T, bubbles at T+1..T+3, ADDI ex_valid at T+4; id_stall high for exactly 3 cycles. Also rerun with MUL_CYCLES=1 -> no stall.
- flush asserted in MUL_BUSY with cnt=2 -> next cycle state=RUN, ex_valid=0, id_stall=0, and the next ID instruction is accepted.
- ex_hold high 2 cycles with STUR in EX -> ex_ctrl, ex_valid and ex_rd stable, id_stall=1; release -> pipeline resumes with no lost or duplicated instruction.
- Opcode 11111111111 with id_valid=1 -> illegal=1 for one cycle, ex_valid=0, ex_ctrl=0. Then rst mid-stream -> all outputs at reset values.

Source files
------------

// File: rtl/pipelined_ctrl_unit.sv
// Registered decode/control stage between IF/ID and ID/EX of the 5-stage ARM pipeline.
// The stage decodes the ID opcode into an 18-bit control word and registers it, with the
// destination register, into EX. It also handles:
//   - load-use hazard bubbles,
//   - multi-cycle MUL occupancy,
//   - flush and downstream hold,
//   - illegal-opcode flagging.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   id_valid, opcode    ID instruction present and its opcode field
//   id_rn, id_rm, id_rd ID source/destination register indices
//   ex_hold, flush      downstream stall, branch-taken squash
//   id_stall            hold PC and IF/ID this cycle
//   ex_valid, ex_ctrl   EX-stage control word and its valid
//   ex_rd               EX-stage destination register
//   illegal             one-cycle pulse when a valid ID opcode matched nothing
module pipelined_ctrl_unit #(
    parameter int unsigned OPC_W      = 11,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [REG_AW-1:0] id_rn,
    input  logic [REG_AW-1:0] id_rm,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_hold,
    input  logic              flush,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [17:0]       ex_ctrl,
    output logic [REG_AW-1:0] ex_rd,
    output logic              illegal
);

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MUL_BUSY = 1'b1;

    localparam logic [REG_AW-1:0] ZERO_REG     = '1;
    localparam logic [3:0]        MUL_CNT_INIT = 4'(MUL_CYCLES - 1);

    // Control word bit positions
    localparam int C_UNCOND_BR  = 0;
    localparam int C_BRANCH     = 1;
    localparam int C_REG2LOC    = 2;
    localparam int C_ALU_SRC    = 3;
    localparam int C_REG_WRITE  = 4;
    localparam int C_IMM        = 6;
    localparam int C_MEM_TO_REG = 7;
    localparam int C_MEM_WRITE  = 8;
    localparam int C_ALU_ON     = 10;
    localparam int C_SET_FLAGS  = 11;
    localparam int C_BRANCH_REG = 12;
    localparam int C_BRANCH_LNK = 13;
    localparam int C_MEM_READ   = 14;
    localparam int C_FWD_LO     = 15;
    localparam int C_FWD_HI     = 16;
    localparam int C_MUL        = 17;

    logic [10:0]       op;
    logic [17:0]       dec_ctrl;
    logic              dec_legal;
    logic              dec_cbz;
    logic              dec_bl;
    logic              uses_rm;
    logic              hazard;
    logic              accept;

    logic              state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ex_valid_q, ex_valid_d;
    logic [17:0]       ex_ctrl_q, ex_ctrl_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
    logic              illegal_q, illegal_d;

    assign op = opcode[OPC_W-1 -: 11];

    // First match wins; unmatched opcodes leave the word all-zero.
    always_comb begin
        dec_ctrl  = '0;
        dec_legal = 1'b1;
        dec_cbz   = 1'b0;
        dec_bl    = 1'b0;
        if (op[10:5] == 6'b000101) begin                     // B
            dec_ctrl[C_UNCOND_BR] = 1'b1;
            dec_ctrl[C_BRANCH]    = 1'b1;
        end else if (op[10:3] == 8'b01010100) begin          // B.cond
            dec_ctrl[C_BRANCH] = 1'b1;
        end else if (op[10:5] == 6'b100101) begin            // BL
            dec_bl                 = 1'b1;
            dec_ctrl[C_UNCOND_BR]  = 1'b1;
            dec_ctrl[C_BRANCH]     = 1'b1;
            dec_ctrl[C_REG_WRITE]  = 1'b1;
            dec_ctrl[C_BRANCH_LNK] = 1'b1;
        end else if (op == 11'b11010110000) begin            // BR
            dec_ctrl[C_BRANCH_REG] = 1'b1;
            dec_ctrl[C_FWD_LO]     = 1'b1;
        end else if (op[10:3] == 8'b10110100) begin          // CBZ
            dec_cbz            = 1'b1;
            dec_ctrl[C_BRANCH] = 1'b1;
            dec_ctrl[C_ALU_ON] = 1'b1;
            dec_ctrl[C_FWD_HI] = 1'b1;
        end else if (op[10:1] == 10'b1001000100) begin       // ADDI
            dec_ctrl[C_ALU_SRC]   = 1'b1;
            dec_ctrl[C_REG_WRITE] = 1'b1;
            dec_ctrl[C_IMM]       = 1'b1;
            dec_ctrl[C_ALU_ON]    = 1'b1;
            dec_ctrl[C_FWD_LO]    = 1'b1;
        end else if (op == 11'b10101011000 || op == 11'b11101011000) begin  // ADDS, SUBS
            dec_ctrl[C_REG2LOC]   = 1'b1;
            dec_ctrl[C_REG_WRITE] = 1'b1;
            dec_ctrl[C_ALU_ON]    = 1'b1;
            dec_ctrl[C_SET_FLAGS] = 1'b1;
            dec_ctrl[C_FWD_HI]    = 1'b1;
            dec_ctrl[C_FWD_LO]    = 1'b1;
        end else if (op == 11'b11111000010) begin            // LDUR
            dec_ctrl[C_ALU_SRC]    = 1'b1;
            dec_ctrl[C_REG_WRITE]  = 1'b1;
            dec_ctrl[C_MEM_TO_REG] = 1'b1;
            dec_ctrl[C_ALU_ON]     = 1'b1;
            dec_ctrl[C_MEM_READ]   = 1'b1;
            dec_ctrl[C_FWD_LO]     = 1'b1;
        end else if (op == 11'b11111000000) begin            // STUR
            dec_ctrl[C_ALU_SRC]   = 1'b1;
            dec_ctrl[C_MEM_WRITE] = 1'b1;
            dec_ctrl[C_ALU_ON]    = 1'b1;
            dec_ctrl[C_FWD_HI]    = 1'b1;
            dec_ctrl[C_FWD_LO]    = 1'b1;
        end else if (op == 11'b10011011000) begin            // MUL
            dec_ctrl[C_REG2LOC]   = 1'b1;
            dec_ctrl[C_REG_WRITE] = 1'b1;
            dec_ctrl[C_ALU_ON]    = 1'b1;
            dec_ctrl[C_FWD_HI]    = 1'b1;
            dec_ctrl[C_FWD_LO]    = 1'b1;
            dec_ctrl[C_MUL]       = 1'b1;
        end else begin
            dec_legal = 1'b0;
        end
    end

    assign uses_rm = dec_ctrl[C_REG2LOC] | dec_ctrl[C_MEM_WRITE] | dec_cbz | dec_ctrl[C_MUL];

    // A load in EX whose result the ID instruction reads; X31 never carries a dependency.
    assign hazard = ex_valid_q & ex_ctrl_q[C_MEM_READ] & (ex_rd_q != ZERO_REG) & id_valid &
                    ((ex_rd_q == id_rn) | (uses_rm & (ex_rd_q == id_rm)));

    assign accept = id_valid & ~hazard & (state_q == ST_RUN) & ~ex_hold & ~flush;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ex_valid_d = ex_valid_q;
        ex_ctrl_d  = ex_ctrl_q;
        ex_rd_d    = ex_rd_q;
        illegal_d  = 1'b0;
        id_stall   = 1'b0;
        if (flush) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
            state_d    = ST_RUN;
            cnt_d      = '0;
        end else if (ex_hold) begin
            id_stall = 1'b1;
        end else if (state_q == ST_MUL_BUSY) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
            cnt_d      = 4'(cnt_q - 4'd1);
            if (cnt_q == 4'd1) begin
                // Last bubble: release IF/ID so the next instruction arrives next cycle.
                state_d = ST_RUN;
            end else begin
                id_stall = 1'b1;
            end
        end else if (accept) begin
            ex_valid_d = dec_legal;
            ex_ctrl_d  = dec_ctrl;
            ex_rd_d    = dec_bl ? ZERO_REG : id_rd;
            illegal_d  = ~dec_legal;
            if (dec_ctrl[C_MUL] && (MUL_CYCLES > 1)) begin
                // MUL stays parked in IF/ID while EX is occupied.
                state_d  = ST_MUL_BUSY;
                cnt_d    = MUL_CNT_INIT;
                id_stall = 1'b1;
            end
        end else begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
            id_stall   = hazard;
        end
        if (rst) begin
            id_stall = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
            ex_rd_q    <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ex_valid_q <= ex_valid_d;
            ex_ctrl_q  <= ex_ctrl_d;
            ex_rd_q    <= ex_rd_d;
            illegal_q  <= illegal_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_ctrl  = ex_ctrl_q;
    assign ex_rd    = ex_rd_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_pipelined_ctrl_unit.sv
// Self-checking bench for pipelined_ctrl_unit. Two instances (MUL_CYCLES 4 and 1) share
// stimulus; a transaction-level reference model predicts both.
module tb_pipelined_ctrl_unit;

    localparam int C_B = 0, C_BCOND = 1, C_BL = 2, C_BR = 3, C_CBZ = 4, C_ADDI = 5;
    localparam int C_ADDS = 6, C_LDUR = 7, C_STUR = 8, C_SUBS = 9, C_MUL = 10;

    typedef struct packed {
        logic [10:0] mask;
        logic [10:0] match;
        logic [17:0] ctrl;
    } dec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [10:0] opcode = '0;
    logic [4:0]  id_rn = '0, id_rm = '0, id_rd = '0;
    logic        ex_hold = 1'b0, flush = 1'b0;

    logic        stall4, stall1, v4, v1, ill4, ill1;
    logic [17:0] c4, c1;
    logic [4:0]  rd4, rd1;

    int checks = 0;
    int errors = 0;

    dec_t        tbl [11];
    int          mc [2] = '{4, 1};
    bit          m_v [2], n_v [2], m_ill [2], n_ill [2], e_stall [2];
    logic [17:0] m_c [2], n_c [2];
    logic [4:0]  m_rd [2], n_rd [2];
    int          m_busy [2], n_busy [2];
    logic        last_stall;

    always #5 clk = ~clk;

    pipelined_ctrl_unit #(.OPC_W(11), .REG_AW(5), .MUL_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .id_rn(id_rn),
        .id_rm(id_rm), .id_rd(id_rd), .ex_hold(ex_hold), .flush(flush), .id_stall(stall4),
        .ex_valid(v4), .ex_ctrl(c4), .ex_rd(rd4), .illegal(ill4)
    );

    pipelined_ctrl_unit #(.OPC_W(11), .REG_AW(5), .MUL_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .id_rn(id_rn),
        .id_rm(id_rm), .id_rd(id_rd), .ex_hold(ex_hold), .flush(flush), .id_stall(stall1),
        .ex_valid(v1), .ex_ctrl(c1), .ex_rd(rd1), .illegal(ill1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [17:0] bt(input int i);
        return 18'(1) << i;
    endfunction

    task automatic init_tbl();
        logic [17:0] f1, f2, f3;
        f1 = bt(15);
        f2 = bt(16);
        f3 = bt(15) | bt(16);
        tbl[C_B]     = '{11'b11111100000, 11'b00010100000, bt(0) | bt(1)};
        tbl[C_BCOND] = '{11'b11111111000, 11'b01010100000, bt(1)};
        tbl[C_BL]    = '{11'b11111100000, 11'b10010100000, bt(0) | bt(1) | bt(4) | bt(13)};
        tbl[C_BR]    = '{11'b11111111111, 11'b11010110000, bt(12) | f1};
        tbl[C_CBZ]   = '{11'b11111111000, 11'b10110100000, bt(1) | bt(10) | f2};
        tbl[C_ADDI]  = '{11'b11111111110, 11'b10010001000, bt(3) | bt(4) | bt(6) | bt(10) | f1};
        tbl[C_ADDS]  = '{11'b11111111111, 11'b10101011000, bt(2) | bt(4) | bt(10) | bt(11) | f3};
        tbl[C_LDUR]  = '{11'b11111111111, 11'b11111000010,
                         bt(3) | bt(4) | bt(7) | bt(10) | bt(14) | f1};
        tbl[C_STUR]  = '{11'b11111111111, 11'b11111000000, bt(3) | bt(8) | bt(10) | f3};
        tbl[C_SUBS]  = '{11'b11111111111, 11'b11101011000, bt(2) | bt(4) | bt(10) | bt(11) | f3};
        tbl[C_MUL]   = '{11'b11111111111, 11'b10011011000, bt(2) | bt(4) | bt(10) | f3 | bt(17)};
    endtask

    function automatic int ref_class(input logic [10:0] op);
        for (int i = 0; i < 11; i++) begin
            if ((op & tbl[i].mask) == tbl[i].match) return i;
        end
        return -1;
    endfunction

    // Model: m_busy counts the bubbles still owed to an issued MUL.
    task automatic model_eval(input int k);
        int          cls;
        logic [17:0] ctrl;
        bit          uses_rm, haz, acc;
        cls     = ref_class(opcode);
        ctrl    = (cls >= 0) ? tbl[cls].ctrl : 18'd0;
        uses_rm = ctrl[2] | ctrl[8] | (cls == C_CBZ) | (cls == C_MUL);
        haz = id_valid && m_v[k] && m_c[k][14] && (m_rd[k] != 5'd31) &&
              ((m_rd[k] == id_rn) || (uses_rm && (m_rd[k] == id_rm)));
        acc = id_valid && !haz && (m_busy[k] == 0) && !ex_hold && !flush;
        n_v[k] = m_v[k];  n_c[k] = m_c[k];  n_rd[k] = m_rd[k];
        n_busy[k] = m_busy[k];  n_ill[k] = 1'b0;
        if (rst) begin
            n_v[k] = 0;  n_c[k] = '0;  n_rd[k] = '0;  n_busy[k] = 0;  e_stall[k] = 0;
        end else if (flush) begin
            n_v[k] = 0;  n_c[k] = '0;  n_busy[k] = 0;  e_stall[k] = 0;
        end else if (ex_hold) begin
            e_stall[k] = 1;
        end else if (m_busy[k] > 0) begin
            n_v[k] = 0;  n_c[k] = '0;  n_busy[k] = m_busy[k] - 1;
            e_stall[k] = (m_busy[k] > 1);
        end else if (acc) begin
            n_v[k]   = (cls >= 0);
            n_c[k]   = ctrl;
            n_rd[k]  = (cls == C_BL) ? 5'd31 : id_rd;
            n_ill[k] = (cls < 0);
            n_busy[k] = (cls == C_MUL) ? mc[k] - 1 : 0;
            e_stall[k] = (n_busy[k] > 0);
        end else begin
            n_v[k] = 0;  n_c[k] = '0;  e_stall[k] = haz;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_eval(0);
        model_eval(1);
        check_eq("stall4", stall4, e_stall[0]);
        check_eq("stall1", stall1, e_stall[1]);
        last_stall = stall4;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_v[k] = n_v[k];  m_c[k] = n_c[k];  m_rd[k] = n_rd[k];
            m_busy[k] = n_busy[k];  m_ill[k] = n_ill[k];
        end
        check_eq("valid4", v4, m_v[0]);
        check_eq("ctrl4", c4, m_c[0]);
        check_eq("rd4", rd4, m_rd[0]);
        check_eq("ill4", ill4, m_ill[0]);
        check_eq("valid1", v1, m_v[1]);
        check_eq("ctrl1", c1, m_c[1]);
        check_eq("rd1", rd1, m_rd[1]);
        check_eq("ill1", ill1, m_ill[1]);
    endtask

    task automatic set_id(input int cls, input logic [4:0] rn, input logic [4:0] rm,
                          input logic [4:0] rd);
        id_valid = 1'b1;
        opcode   = tbl[cls].match;
        id_rn    = rn;
        id_rm    = rm;
        id_rd    = rd;
    endtask

    function automatic logic [4:0] rnd_reg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 5'd31 : 5'(r);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int stalls, addi_at, rc;
        init_tbl();

        // Reset state
        rst = 1'b1;
        cycle();
        check_eq("rst_valid", v4, 0);
        check_eq("rst_ctrl", c4, 0);
        check_eq("rst_rd", rd4, 0);
        check_eq("rst_stall", last_stall, 0);
        rst = 1'b0;

        // ADDS decode
        set_id(C_ADDS, 5'd1, 5'd2, 5'd3);
        cycle();
        check_eq("adds_ctrl", c4, 18'h18C14);
        check_eq("adds_valid", v4, 1);
        check_eq("adds_rd", rd4, 3);
        check_eq("adds_stall", last_stall, 0);

        // Load-use hazard, then X31 load with no hazard
        set_id(C_LDUR, 5'd1, 5'd0, 5'd5);
        cycle();
        set_id(C_ADDS, 5'd2, 5'd5, 5'd6);
        cycle();
        check_eq("lu_stall", last_stall, 1);
        check_eq("lu_bubble", v4, 0);
        cycle();
        check_eq("lu_resume_stall", last_stall, 0);
        check_eq("lu_resume_rd", rd4, 6);
        set_id(C_LDUR, 5'd1, 5'd0, 5'd31);
        cycle();
        set_id(C_ADDS, 5'd2, 5'd31, 5'd6);
        cycle();
        check_eq("x31_stall", last_stall, 0);
        check_eq("x31_valid", v4, 1);

        // MUL then ADDI with upstream honouring id_stall
        set_id(C_MUL, 5'd1, 5'd2, 5'd4);
        stalls  = 0;
        addi_at = -1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (i == 0) check_eq("mul1_stall", stall1, 0);
            if (last_stall) stalls++;
            if (v4 && c4 == tbl[C_ADDI].ctrl && addi_at < 0) addi_at = i;
            if (!last_stall) set_id(C_ADDI, 5'd1, 5'd0, 5'd9);
        end
        check_eq("mul_stalls", stalls, 3);
        check_eq("mul_addi_slot", addi_at, 4);

        // Flush in MUL_BUSY with cnt=2
        set_id(C_MUL, 5'd1, 5'd2, 5'd4);
        cycle();
        cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check_eq("flush_valid", v4, 0);
        set_id(C_ADDI, 5'd1, 5'd0, 5'd10);
        cycle();
        check_eq("flush_stall", last_stall, 0);
        check_eq("flush_accept", v4, 1);
        check_eq("flush_rd", rd4, 10);

        // Hold with STUR in EX
        set_id(C_STUR, 5'd1, 5'd2, 5'd7);
        cycle();
        set_id(C_ADDI, 5'd0, 5'd0, 5'd8);
        ex_hold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            check_eq("hold_stall", last_stall, 1);
            check_eq("hold_ctrl", c4, tbl[C_STUR].ctrl);
            check_eq("hold_rd", rd4, 7);
            check_eq("hold_valid", v4, 1);
        end
        ex_hold = 1'b0;
        cycle();
        check_eq("hold_release_ctrl", c4, tbl[C_ADDI].ctrl);
        check_eq("hold_release_rd", rd4, 8);
        id_valid = 1'b0;
        cycle();
        check_eq("hold_no_dup", v4, 0);

        // Illegal opcode, then reset mid-MUL
        id_valid = 1'b1;
        opcode   = 11'b11111111111;
        cycle();
        check_eq("ill_pulse", ill4, 1);
        check_eq("ill_valid", v4, 0);
        check_eq("ill_ctrl", c4, 0);
        id_valid = 1'b0;
        cycle();
        check_eq("ill_clear", ill4, 0);
        set_id(C_MUL, 5'd1, 5'd2, 5'd4);
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        check_eq("rst2_valid", v4, 0);
        check_eq("rst2_ctrl", c4, 0);
        check_eq("rst2_rd", rd4, 0);
        check_eq("rst2_stall", last_stall, 0);
        rst = 1'b0;
        set_id(C_ADDS, 5'd1, 5'd2, 5'd3);
        cycle();
        check_eq("rst2_run_stall", last_stall, 0);
        check_eq("rst2_run_valid", v4, 1);

        // Random traffic; upstream keeps the ID instruction while stalled
        for (int i = 0; i < 800; i++) begin
            rst     = ($urandom_range(0, 99) == 0);
            flush   = ($urandom_range(0, 19) == 0);
            ex_hold = ($urandom_range(0, 9) == 0);
            if (!last_stall) begin
                id_valid = ($urandom_range(0, 99) < 85);
                rc = $urandom_range(0, 12);
                if (rc <= 10) opcode = tbl[rc].match | (11'($urandom) & ~tbl[rc].mask);
                else if (rc == 11) opcode = 11'($urandom);
                else opcode = 11'b11111111111;
                id_rn = rnd_reg();
                id_rm = rnd_reg();
                id_rd = rnd_reg();
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
